rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares one registered-output ROM read port (enable plus address in, two-register read pipeline, data out) among NREQ requesters in the L0MDT trigger datapath. Requesters raise a request with an address; the arbiter grants at most one per clock, drives the ROM port and returns data tagged to the winning requester once the ROM pipeline delay has elapsed. Full throughput: one lookup issued and one returned per cycle.

## Interface

- NREQ, 4: number of requesters (2..16)
- MXADRB, 9: ROM address width
- MXDATB, 11: ROM data width
- IDW, 2: requester-id width, ceil(log2(NREQ)); must be at least 1

- clk  in  1  clock; also drives the ROM clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, level
- addr  in  NREQ*MXADRB  requester i address at bits [i*MXADRB +: MXADRB]
- hold  in  1  when high, no grants are issued; the in-flight pipeline drains
- gnt  out  NREQ  one-hot combinational acknowledge; transfer = req[i] & gnt[i] at a rising edge
- rom_ena  out  1  ROM enable, registered
- rom_addr  out  MXADRB  ROM address, registered
- rom_dout  in  MXDATB  ROM data output
- rd_valid  out  1  returned data valid, registered
- rd_id  out  IDW  requester that owns rd_data, registered
- rd_data  out  MXDATB  equals rom_dout (pass-through)

## Operation

- Grant logic:
  - gnt is 0 while rst or hold is high.
  - Otherwise exactly one gnt bit is high whenever any req bit is high; gnt is all zero when req is all zero.
  - gnt depends only on req, hold, rst and the pointer. It never depends on addr.
- Round-robin:
  - A registered pointer holds the id of the last granted requester.
  - Search order is pointer+1, pointer+2, … wrapping modulo NREQ.
  - The pointer updates to the winner only on a transfer.
  - Reset value of the pointer is NREQ-1, so requester 0 has first priority after reset.
- Requester rules:
  - addr[i] must be stable while req[i] is high and gnt[i] is low.
  - A requester may hold req high across consecutive transfers, presenting a new address each cycle. It is then granted again only when its round-robin turn returns, or immediately if it is the sole requester.
- Issue:
  - On a transfer, the next cycle has rom_ena=1 and rom_addr=the winner's addr.
  - With no transfer, rom_ena=0 and rom_addr holds its previous value.
- Tag pipeline:
  - A 3-stage shift register carries {valid, id}. Stage 1 is loaded with the transfer.
  - rd_valid and rd_id are stage 3.
  - The ROM's second register updates every cycle regardless of enable, so rd_data is only meaningful while rd_valid=1.
- Reset:
  - The pointer resets to NREQ-1. All tag stages are cleared.
  - Reset values: rom_ena=0, rom_addr=0, rd_valid=0, rd_id=0. gnt=0 combinationally during reset.
  - Reset mid-operation discards all in-flight lookups: no rd_valid is produced for them, even though ROM registers still shift.
- hold asserted mid-stream: already-issued lookups still return. Grants resume on the first cycle hold is low, from the current pointer.

## Timing

- Transfer at edge E0.
- Cycle after E0: rom_ena=1 and rom_addr is valid.
- ROM first-stage register loads at E1.
- ROM output register loads at E2.
- Cycle after E2: rd_valid=1, rd_id=winner, rd_data=rom[addr]. Request-to-data latency is 3 cycles.
- Back-to-back transfers at E0, E1, E2 return on 3 consecutive cycles, in order, with no gaps.
- Combinational path: req/hold → gnt only. All other outputs are registered, except rd_data, which is a wire.

## Configuration

- ROM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest-index active requester always wins, and the pointer register is not implemented.
  - Undefined (default): round-robin as described above.
- Latency, handshake and reset behaviour are identical in both modes.

## Test plan

- Reset, then req=0001 with addr0=0x005 → gnt=0001; next cycle rom_ena=1 and rom_addr=0x005; 3 cycles after the transfer, rd_valid=1, rd_id=0, rd_data=rom[0x005]; afterwards rd_valid=0.
- req=1111 held for 8 cycles with constant addresses → grant order 0,1,2,3,0,1,2,3; rd_valid high for 8 consecutive cycles with rd_id in the same order. With ROM_ARB_FIXED_PRIO_EN defined: all 8 grants go to requester 0.
- req=0100, addr2 stepping 0x000..0x00F each cycle → 16 consecutive grants to requester 2; rd_data sequence equals rom[0x000..0x00F] with no gaps.
- req=1010 with hold=1 for 4 cycles → gnt=0 and rom_ena=0 throughout; hold drops → gnt=0010 first (pointer=3 after reset), then 1000.
- Three transfers issued, then rst pulsed for 1 cycle 1 cycle after the last transfer → no rd_valid for the discarded lookups; after reset, req=0010 is granted, with pointer behaviour as from fresh reset.
- req=1001 with addr3=0x1FF and addr0=0x000 → both addresses round-trip correctly through the ROM pipeline (address extremes).

Source files
------------

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Shares one registered-output ROM read port among NREQ requesters,
//            returning tagged read data three cycles after each grant.
//            Define ROM_ARB_FIXED_PRIO_EN for fixed priority; default is
//            round-robin.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
  parameter int NREQ   = 4,
  parameter int MXADRB = 9,
  parameter int MXDATB = 11,
  parameter int IDW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*MXADRB-1:0] addr,
  input  logic                   hold,
  output logic [NREQ-1:0]        gnt,
  output logic                   rom_ena,
  output logic [MXADRB-1:0]      rom_addr,
  input  logic [MXDATB-1:0]      rom_dout,
  output logic                   rd_valid,
  output logic [IDW-1:0]         rd_id,
  output logic [MXDATB-1:0]      rd_data
);

  localparam int c_STAGES = 3;

  logic              w_found;
  logic [IDW-1:0]    w_win_id;
  logic              w_xfer;
  logic [NREQ-1:0]   w_gnt;
  logic [MXADRB-1:0] w_win_addr;

  logic              r_rom_ena;
  logic [MXADRB-1:0] r_rom_addr;
  logic [c_STAGES-1:0] r_tag_v;
  logic [IDW-1:0]    r_tag_id [c_STAGES];

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Lowest index wins; scanning downward leaves the lowest active one last.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_found  = 1'b1;
        w_win_id = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] r_ptr;

  // Scan from farthest to nearest so pointer+1 has the final say.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_win_id = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_xfer) begin
      r_ptr <= w_win_id;
    end
  end
`endif

  assign w_xfer = w_found & ~rst & ~hold;

  always_comb begin
    w_gnt      = '0;
    w_win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt[i] = w_xfer && (w_win_id == IDW'(i));
      if (w_win_id == IDW'(i)) begin
        w_win_addr = addr[i*MXADRB +: MXADRB];
      end
    end
  end

  // Tag stage 0 runs alongside rom_ena; stage 2 lines up with the ROM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_ena  <= 1'b0;
      r_rom_addr <= '0;
      r_tag_v    <= '0;
      for (int s = 0; s < c_STAGES; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_rom_ena <= w_xfer;
      if (w_xfer) begin
        r_rom_addr <= w_win_addr;
      end
      r_tag_v     <= {r_tag_v[c_STAGES-2:0], w_xfer};
      r_tag_id[0] <= w_xfer ? w_win_id : '0;
      for (int s = 1; s < c_STAGES; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign gnt      = w_gnt;
  assign rom_ena  = r_rom_ena;
  assign rom_addr = r_rom_addr;
  assign rd_valid = r_tag_v[c_STAGES-1];
  assign rd_id    = r_tag_id[c_STAGES-1];
  assign rd_data  = rom_dout;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Scoreboard bench for rom_arbiter with a two-register ROM model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 9;
  localparam int DW   = 11;
  localparam int IDW  = 2;
`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic              rom_ena;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_dout;
  logic              rd_valid;
  logic [IDW-1:0]    rd_id;
  logic [DW-1:0]     rd_data;

  int total = 0;
  int bad   = 0;

  logic [IDW+DW-1:0] sb[$];
  logic [2:0]        m_v    = '0;
  logic              m_ena  = 1'b0;
  logic [AW-1:0]     m_addr = '0;

  logic [DW-1:0] rom_q1 = '0;
  logic [DW-1:0] rom_q2 = '0;

  always #5 clk = ~clk;

  rom_arbiter #(.NREQ(NREQ), .MXADRB(AW), .MXDATB(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .hold(hold), .gnt(gnt),
    .rom_ena(rom_ena), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a[1:0], a} ^ 11'h5A3;
  endfunction

  // External ROM: enabled first register, free-running output register.
  always @(posedge clk) begin
    if (rom_ena) rom_q1 <= rom_f(rom_addr);
    rom_q2 <= rom_q1;
  end
  assign rom_dout = rom_q2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every returned word must match the oldest outstanding lookup.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid at %0t: got rd_id %h rd_data %h expected none", $time, rd_id, rd_data);
      end else begin
        logic [IDW+DW-1:0] e;
        e = sb.pop_front();
        chk("rd_id", 32'(rd_id), 32'(e[IDW+DW-1:DW]));
        chk("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic h, input logic rs, input logic [3:0] eg);
    int wid;
    logic [AW-1:0] wa;
    req = r; hold = h; rst = rs;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    wid = -1;
    wa  = '0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) wid = i;
    if (wid >= 0) wa = addr[wid*AW +: AW];
    @(posedge clk);
    #1;
    if (rs) begin
      if (m_v[0]) void'(sb.pop_back());
      if (m_v[1]) void'(sb.pop_back());
      m_v = '0; m_ena = 1'b0; m_addr = '0;
    end else begin
      m_v   = {m_v[1:0], wid >= 0};
      m_ena = (wid >= 0);
      if (wid >= 0) begin
        m_addr = wa;
        sb.push_back({2'(wid), rom_f(wa)});
      end
    end
    chk("rom_ena", 32'(rom_ena), 32'(m_ena));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("rd_valid", 32'(rd_valid), 32'(m_v[2]));
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b1, 4'b0000);
  endtask

  task automatic drain();
    for (int j = 0; j < 4; j++) drive(4'b0000, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; req = '0; hold = 1'b0; addr = '0;
    @(posedge clk);
    #1;
    drive(4'b1111, 1'b0, 1'b1, 4'b0000);
    drive(4'b1111, 1'b0, 1'b1, 4'b0000);
    chk("rd_id_reset", 32'(rd_id), 32'd0);

    // Single lookup, latency 3.
    do_reset();
    set_addr(0, 9'h005);
    drive(4'b0001, 1'b0, 1'b0, 4'b0001);
    drain();

    // All four requesting.
    do_reset();
    set_addr(0, 9'h010); set_addr(1, 9'h021); set_addr(2, 9'h132); set_addr(3, 9'h1FE);
    for (int k = 0; k < 8; k++) drive(4'b1111, 1'b0, 1'b0, FIXED ? 4'b0001 : 4'(1 << (k % 4)));
    drain();

    // Sole requester streaming new addresses.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_addr(2, 9'(k));
      drive(4'b0100, 1'b0, 1'b0, 4'b0100);
    end
    drain();

    // Hold blocks grants, then resumes from the reset pointer.
    do_reset();
    set_addr(1, 9'h0A1); set_addr(3, 9'h0B3);
    for (int k = 0; k < 4; k++) drive(4'b1010, 1'b1, 1'b0, 4'b0000);
    drive(4'b1010, 1'b0, 1'b0, 4'b0010);
    drive(4'b1010, 1'b0, 1'b0, FIXED ? 4'b0010 : 4'b1000);
    drain();

    // Reset mid-flight discards the lookups still in the tag pipeline.
    do_reset();
    set_addr(0, 9'h011); set_addr(1, 9'h022); set_addr(2, 9'h033);
    drive(4'b0111, 1'b0, 1'b0, 4'b0001);
    drive(4'b0111, 1'b0, 1'b0, FIXED ? 4'b0001 : 4'b0010);
    drive(4'b0111, 1'b0, 1'b0, FIXED ? 4'b0001 : 4'b0100);
    drive(4'b0000, 1'b0, 1'b1, 4'b0000);
    set_addr(1, 9'h0C5);
    drive(4'b0010, 1'b0, 1'b0, 4'b0010);
    drive(4'b0011, 1'b0, 1'b0, 4'b0001);
    drain();

    // Address extremes.
    do_reset();
    set_addr(3, 9'h1FF); set_addr(0, 9'h000);
    drive(4'b1001, 1'b0, 1'b0, 4'b0001);
    drive(4'b1001, 1'b0, 1'b0, FIXED ? 4'b0001 : 4'b1000);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
